// File: rtl/seg_memory.sv
// seg_memory: MIPS MEM stage. Resolves branches, performs byte/half/word
// loads and stores on an internal data RAM, and registers the MEM/WB
// outputs feeding write-back. After reset a clear FSM zeroes the RAM one
// word per cycle; the stage reports o_ready only once that sweep is done.
// The byte-lane logic assumes LEN = 32 (four byte lanes per word).
module seg_memory #(
    parameter int LEN         = 32,
    parameter int NB_ADDR     = 5,
    parameter int NB_CTRL_WB  = 2,
    parameter int NB_CTRL_M   = 3,
    parameter int NB_RAM_ADDR = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic [LEN-1:0]         i_PC_branch,
    input  logic [LEN-1:0]         i_ALU_result,
    input  logic [LEN-1:0]         i_write_data,
    input  logic [NB_ADDR-1:0]     i_write_register,
    input  logic                   i_ALU_zero,
    input  logic [1:0]             i_mem_size,
    input  logic                   i_load_unsigned,
    input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]   i_ctrl_mem_bus,
    input  logic [NB_RAM_ADDR-1:0] i_dbg_addr,
    output logic                   o_ready,
    output logic                   o_PCSrc,
    output logic [LEN-1:0]         o_PC_branch,
    output logic [LEN-1:0]         o_read_data,
    output logic [LEN-1:0]         o_ALU_result,
    output logic [NB_ADDR-1:0]     o_write_register,
    output logic [NB_CTRL_WB-1:0]  o_ctrl_wb_bus,
    output logic                   o_misaligned,
    output logic [LEN-1:0]         o_dbg_data
);

    localparam int   DEPTH    = 2 ** NB_RAM_ADDR;
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic                   state;
    logic [NB_RAM_ADDR-1:0] clr_cnt;
    logic [LEN-1:0]         mem [DEPTH];

    logic                   ready;
    logic                   act;
    logic                   branch;
    logic                   mem_read;
    logic                   mem_write;
    logic [NB_RAM_ADDR-1:0] word_addr;
    logic [1:0]             off;
    logic                   mis_addr;
    logic                   misaligned;
    logic                   wr_en;
    logic [3:0]             byte_en;
    logic [LEN-1:0]         wr_lanes;
    logic [LEN-1:0]         rd_word;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [LEN-1:0]         load_data;
    logic                   unused_addr_bits;

    assign ready     = (state == ST_RUN);
    assign o_ready   = ready;
    assign act       = i_valid & ~i_stall & ready;
    assign branch    = i_ctrl_mem_bus[2];
    assign mem_read  = i_ctrl_mem_bus[1];
    assign mem_write = i_ctrl_mem_bus[0];

    // Address bits above the RAM depth are dropped, so accesses wrap
    assign word_addr        = i_ALU_result[NB_RAM_ADDR+1:2];
    assign off              = i_ALU_result[1:0];
    assign unused_addr_bits = &{1'b0, i_ALU_result[LEN-1:NB_RAM_ADDR+2]};

    assign mis_addr   = ((i_mem_size == 2'b01) & off[0]) |
                        (i_mem_size[1] & (off != 2'b00));
    assign misaligned = (mem_read | mem_write) & mis_addr;
    assign wr_en      = act & mem_write & ~mis_addr;

    assign o_PCSrc     = act & branch & i_ALU_zero;
    assign o_PC_branch = i_PC_branch;

    // Replicate store data across lanes and pick which lanes get written
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = i_write_data;
        case (i_mem_size)
            2'b00: begin
                byte_en  = 4'b0001 << off;
                wr_lanes = {4{i_write_data[7:0]}};
            end
            2'b01: begin
                byte_en  = off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{i_write_data[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = i_write_data;
            end
        endcase
    end

    // Combinational RAM read, lane select and sign/zero extension
    always_comb begin
        rd_word   = mem[word_addr];
        rd_byte   = rd_word[{off, 3'b000} +: 8];
        rd_half   = off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        if (mem_read & ~mem_write & ~mis_addr) begin
            case (i_mem_size)
                2'b00:   load_data = i_load_unsigned ? {{(LEN-8){1'b0}}, rd_byte}
                                                     : {{(LEN-8){rd_byte[7]}}, rd_byte};
                2'b01:   load_data = i_load_unsigned ? {{(LEN-16){1'b0}}, rd_half}
                                                     : {{(LEN-16){rd_half[15]}}, rd_half};
                default: load_data = rd_word;
            endcase
        end
    end

    // Clear FSM: sweep every word once after reset, then run
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) begin
                state <= ST_RUN;
            end
        end
    end

    // RAM write port, shared between the clear sweep and byte-enabled stores
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int k = 0; k < 4; k++) begin
                    if (byte_en[k]) begin
                        mem[word_addr][8*k +: 8] <= wr_lanes[8*k +: 8];
                    end
                end
            end
        end
    end

    // MEM/WB pipeline registers: bubble during clear or on invalid, hold on stall
    always_ff @(posedge i_clk) begin
        if (i_rst || !ready) begin
            o_read_data      <= '0;
            o_ALU_result     <= '0;
            o_write_register <= '0;
            o_ctrl_wb_bus    <= '0;
            o_misaligned     <= 1'b0;
        end else if (!i_stall) begin
            if (!i_valid) begin
                o_read_data      <= '0;
                o_ALU_result     <= '0;
                o_write_register <= '0;
                o_ctrl_wb_bus    <= '0;
                o_misaligned     <= 1'b0;
            end else begin
                o_read_data      <= load_data;
                o_ALU_result     <= i_ALU_result;
                o_write_register <= i_write_register;
                o_ctrl_wb_bus    <= {i_ctrl_wb_bus[1] & ~misaligned, i_ctrl_wb_bus[0]};
                o_misaligned     <= misaligned;
            end
        end
    end

    // Debug read port: registered word at i_dbg_addr, pre-write value on collision
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

endmodule

// File: tb/tb_seg_memory.sv
// tb_seg_memory: scoreboard bench for seg_memory. Each transaction pushes
// its expected MEM/WB contents when driven; they are popped and compared
// one cycle later when the stage registers its outputs.
module tb_seg_memory;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        stall;
    logic [31:0] pcBranch;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
    logic        aluZero;
    logic [1:0]  memSize;
    logic        loadUnsigned;
    logic [1:0]  ctrlWb;
    logic [2:0]  ctrlMem;
    logic [7:0]  dbgAddr;

    logic        ready;
    logic        pcSrc;
    logic [31:0] pcBranchOut;
    logic [31:0] readData;
    logic [31:0] aluOut;
    logic [4:0]  writeRegOut;
    logic [1:0]  ctrlWbOut;
    logic        misaligned;
    logic [31:0] dbgData;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    exp_t lastExp;
    int   total = 0;
    int   bad   = 0;

    seg_memory dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_valid          (valid),
        .i_stall          (stall),
        .i_PC_branch      (pcBranch),
        .i_ALU_result     (aluResult),
        .i_write_data     (writeData),
        .i_write_register (writeReg),
        .i_ALU_zero       (aluZero),
        .i_mem_size       (memSize),
        .i_load_unsigned  (loadUnsigned),
        .i_ctrl_wb_bus    (ctrlWb),
        .i_ctrl_mem_bus   (ctrlMem),
        .i_dbg_addr       (dbgAddr),
        .o_ready          (ready),
        .o_PCSrc          (pcSrc),
        .o_PC_branch      (pcBranchOut),
        .o_read_data      (readData),
        .o_ALU_result     (aluOut),
        .o_write_register (writeRegOut),
        .o_ctrl_wb_bus    (ctrlWbOut),
        .o_misaligned     (misaligned),
        .o_dbg_data       (dbgData)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Compare the registered MEM/WB outputs against one expectation record
    task automatic compareRegs(input string tag, input exp_t e);
        checkOutput({tag, "_rd"},   readData,           e.rd);
        checkOutput({tag, "_alu"},  aluOut,             e.alu);
        checkOutput({tag, "_wreg"}, {27'd0, writeRegOut}, {27'd0, e.wreg});
        checkOutput({tag, "_wb"},   {30'd0, ctrlWbOut}, {30'd0, e.wb});
        checkOutput({tag, "_mis"},  {31'd0, misaligned}, {31'd0, e.mis});
    endtask

    // Drive one EX/MEM slot at negedge, check branch outputs, push the
    // expectation, then pop and compare after the capturing edge
    task automatic applyStimulus(
        input string       tag,
        input logic        v,
        input logic        s,
        input logic [2:0]  cm,
        input logic [1:0]  cw,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic        z,
        input logic [31:0] expRd,
        input logic        expMis,
        input logic        expPc
    );
        exp_t e;
        @(negedge clk);
        valid        = v;
        stall        = s;
        ctrlMem      = cm;
        ctrlWb       = cw;
        memSize      = sz;
        loadUnsigned = uns;
        aluResult    = addr;
        writeData    = wdata;
        aluZero      = z;
        writeReg     = 5'($urandom);
        pcBranch     = $urandom;
        #1;
        checkOutput({tag, "_pcsrc"}, {31'd0, pcSrc}, {31'd0, expPc});
        checkOutput({tag, "_pcpass"}, pcBranchOut, pcBranch);
        if (!s) begin
            if (v) begin
                e.rd   = expRd;
                e.alu  = addr;
                e.wreg = writeReg;
                e.wb   = expMis ? {1'b0, cw[0]} : cw;
                e.mis  = expMis;
            end else begin
                e.rd = '0; e.alu = '0; e.wreg = '0; e.wb = '0; e.mis = 1'b0;
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (s) begin
            compareRegs({tag, "_hold"}, lastExp);
        end else if (sbq.size() == 0) begin
            checkOutput({tag, "_sbq_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            compareRegs(tag, e);
            lastExp = e;
        end
        valid = 1'b0;
        stall = 1'b0;
    endtask

    // Registered debug read of one word
    task automatic checkDbg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        @(negedge clk);
        dbgAddr = addr;
        @(posedge clk);
        #1;
        checkOutput(tag, dbgData, exp);
    endtask

    // Reset, verify cleared outputs, then measure the clear sweep length
    task automatic doReset(input string tag);
        int cnt;
        @(negedge clk);
        rst       = 1'b1;
        valid     = 1'b1;
        stall     = 1'b0;
        ctrlMem   = 3'b101;
        ctrlWb    = 2'b11;
        memSize   = 2'b10;
        aluZero   = 1'b1;
        aluResult = 32'h10;
        writeData = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_rst_ready"}, {31'd0, ready}, 32'd0);
        checkOutput({tag, "_rst_pcsrc"}, {31'd0, pcSrc}, 32'd0);
        checkOutput({tag, "_rst_rd"}, readData, 32'd0);
        checkOutput({tag, "_rst_alu"}, aluOut, 32'd0);
        checkOutput({tag, "_rst_wb"}, {30'd0, ctrlWbOut}, 32'd0);
        checkOutput({tag, "_rst_dbg"}, dbgData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (!ready && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 100) begin
                checkOutput({tag, "_clr_pcsrc"}, {31'd0, pcSrc}, 32'd0);
            end
        end
        valid = 1'b0;
        checkOutput({tag, "_ready_lat"}, cnt, 32'd256);
        checkOutput({tag, "_clr_wb"}, {30'd0, ctrlWbOut}, 32'd0);
        checkOutput({tag, "_clr_alu"}, aluOut, 32'd0);
        lastExp.rd = '0; lastExp.alu = '0; lastExp.wreg = '0; lastExp.wb = '0; lastExp.mis = 1'b0;
    endtask

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; stall = 1'b0; pcBranch = '0; aluResult = '0;
        writeData = '0; writeReg = '0; aluZero = 1'b0; memSize = '0;
        loadUnsigned = 1'b0; ctrlWb = '0; ctrlMem = '0; dbgAddr = '0;

        doReset("r1");
        checkDbg("dbg0", 8'd0, 32'd0);
        checkDbg("dbg128", 8'd128, 32'd0);
        checkDbg("dbg255", 8'd255, 32'd0);

        // Word store/load with debug collision on word 4
        dbgAddr = 8'd4;
        applyStimulus("sw10", 1, 0, 3'b001, 2'b00, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'd0, 0, 0);
        checkOutput("dbg_old", dbgData, 32'd0);
        @(posedge clk); #1;
        checkOutput("dbg_new", dbgData, 32'hDEADBEEF);
        applyStimulus("lw10", 1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 0);

        // Sub-word loads and byte store
        applyStimulus("lbu13", 1, 0, 3'b010, 2'b11, 2'b00, 1, 32'h13, 32'h0, 0, 32'h000000DE, 0, 0);
        applyStimulus("lb13",  1, 0, 3'b010, 2'b11, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0, 0);
        applyStimulus("lh12",  1, 0, 3'b010, 2'b11, 2'b01, 0, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 0, 0);
        applyStimulus("sb11",  1, 0, 3'b001, 2'b00, 2'b00, 0, 32'h11, 32'hAAAAAA55, 0, 32'd0, 0, 0);
        applyStimulus("lw10b", 1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0, 0);
        applyStimulus("lhu10", 1, 0, 3'b010, 2'b11, 2'b01, 1, 32'h10, 32'h0, 0, 32'h000055EF, 0, 0);
        applyStimulus("lb10",  1, 0, 3'b010, 2'b11, 2'b00, 0, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 0, 0);
        applyStimulus("sh16",  1, 0, 3'b001, 2'b00, 2'b01, 0, 32'h16, 32'hFFFF8001, 0, 32'd0, 0, 0);
        applyStimulus("lw14",  1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h14, 32'h0, 0, 32'h80010000, 0, 0);
        applyStimulus("lh16",  1, 0, 3'b010, 2'b11, 2'b01, 0, 32'h16, 32'h0, 0, 32'hFFFF8001, 0, 0);

        // Misaligned accesses leave RAM untouched and kill RegWrite
        applyStimulus("sw12m", 1, 0, 3'b001, 2'b10, 2'b10, 0, 32'h12, 32'h12345678, 0, 32'd0, 1, 0);
        applyStimulus("lh11m", 1, 0, 3'b010, 2'b11, 2'b01, 0, 32'h11, 32'h0, 0, 32'd0, 1, 0);
        applyStimulus("lw10c", 1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0, 0);

        // Read+write together writes only; address wrap; top word
        applyStimulus("rw20",  1, 0, 3'b011, 2'b10, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 32'd0, 0, 0);
        applyStimulus("lw20",  1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, 0, 0);
        applyStimulus("swwrap",1, 0, 3'b001, 2'b00, 2'b10, 0, 32'h418, 32'h11223344, 0, 32'd0, 0, 0);
        applyStimulus("lw18",  1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h18, 32'h0, 0, 32'h11223344, 0, 0);
        applyStimulus("sw3fc", 1, 0, 3'b001, 2'b00, 2'b10, 0, 32'h3FC, 32'hA5A5A5A5, 0, 32'd0, 0, 0);
        applyStimulus("lw3fc", 1, 0, 3'b010, 2'b11, 2'b11, 0, 32'h3FC, 32'h0, 0, 32'hA5A5A5A5, 0, 0);
        checkDbg("dbg255w", 8'd255, 32'hA5A5A5A5);

        // Branch resolution, stall hold and bubble
        applyStimulus("br_t",  1, 0, 3'b100, 2'b00, 2'b10, 0, 32'h0, 32'h0, 1, 32'd0, 0, 1);
        applyStimulus("br_nt", 1, 0, 3'b100, 2'b00, 2'b10, 0, 32'h0, 32'h0, 0, 32'd0, 0, 0);
        applyStimulus("lw10d", 1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0, 0);
        applyStimulus("stall", 1, 1, 3'b101, 2'b10, 2'b10, 0, 32'h30, 32'h00000099, 1, 32'd0, 0, 0);
        applyStimulus("lw30",  1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h30, 32'h0, 0, 32'd0, 0, 0);
        applyStimulus("bubble",0, 0, 3'b110, 2'b11, 2'b10, 0, 32'h10, 32'h0, 1, 32'd0, 0, 0);

        // Reset mid-run wipes stored words
        doReset("r2");
        applyStimulus("lw10z", 1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h10, 32'h0, 0, 32'd0, 0, 0);
        applyStimulus("lw20z", 1, 0, 3'b010, 2'b11, 2'b10, 0, 32'h20, 32'h0, 0, 32'd0, 0, 0);
        checkDbg("dbg255z", 8'd255, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
